axi_receive_fifo: RTL and testbench
===================================

// Module: axi_receive_fifo
// PURPOSE
// - Parametrised successor to axi_receive: AXI-style valid/ready slave channel receiver with DEPTH-entry FIFO buffering.
// - Address mode (IS_ADDR=1): decodes the byte address into a word-granular mem ID with range/alignment checking.
// - Data mode (IS_ADDR=0): passes data through, resized to DATA_WIDTH.
// - Sits between the PS AXI write-address/write-data channels and the register-map logic; decouples PS bursts from a slow consumer.
// PARAMETERS
// - BUS_WIDTH  32            width of s_data
// - DATA_WIDTH 32            width of data
// - DEPTH      4             FIFO entries; power of 2, >=2
// - IS_ADDR    0             1 = address decode mode, 0 = data passthrough
// - ADDR_BASE  32'h9000_0000 byte address mapped to ID 0 (address mode only)
// - ID_NUM     64            number of valid IDs; decoded ID range 0..ID_NUM-1
// PORTS
// - clk         in   1                   clock
// - rst_n       in   1                   asynchronous active-low reset
// - s_valid     in   1                   upstream beat valid
// - s_data      in   BUS_WIDTH           upstream beat (byte address or data)
// - s_ready     out  1                   FIFO can accept a beat
// - valid_data  out  1                   head entry present
// - data        out  DATA_WIDTH          head entry (mem ID or data)
// - dev_rdy     in   1                   consumer pops head when valid_data && dev_rdy
// - decode_err  out  1                   head entry was out of range or misaligned (address mode only)
// - count       out  $clog2(DEPTH)+1     current occupancy
// - err_cnt     out  16                  decode-error counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async assert, sync release): all pointers/count 0; s_ready=0 during reset, 1 first cycle after; valid_data=0, data=0, decode_err=0, err_cnt=0; stored contents discarded.
// - Storage: pointers are $clog2(DEPTH)+1 bits with MSB wrap bit; full = equal indices, differing MSB; empty = pointers equal.
// - s_ready = !full; registered occupancy only, no combinational path from dev_rdy.
// - Push = s_valid && s_ready; pop = valid_data && dev_rdy. Beat accepted in cycle N appears on valid_data/data in N+1 (1-cycle latency).
// - valid_data = !empty; data/decode_err show the head entry, stable until popped; both 0 when empty.
// - Simultaneous push+pop: count unchanged, both pointers advance.
//   - When full, no push is possible; the pop frees space and s_ready rises the next cycle.
//   - When empty, pop is impossible; a pushed beat appears next cycle.
// - Address decode (IS_ADDR=1), computed at push time and stored with the entry; addr = s_data:
//   - err if addr < ADDR_BASE
//   - err if addr[1:0] != 0
//   - err if ((addr-ADDR_BASE)>>2) >= ID_NUM
//   - if no err: stored value = (addr-ADDR_BASE)>>2
//   - if err: stored value = ID_NUM (the invalid-ID sentinel), decode_err bit = 1
//   - Subtraction is BUS_WIDTH bits wide; result is zero-extended or truncated to DATA_WIDTH.
// - Data mode (IS_ADDR=0):
//   - stored value = s_data[DATA_WIDTH-1:0] if DATA_WIDTH <= BUS_WIDTH, else s_data zero-extended
//   - decode_err always 0
// - Pointer wrap: index rolls from DEPTH-1 to 0, toggling the MSB; occupancy stays correct across any number of wraps.
// - Reset mid-operation flushes all in-flight entries immediately; no partial beats are delivered after release.
// CONFIGURATION
// - Macro AXI_RX_ERR_CNT_EN defined:
//   - err_cnt increments by 1 on each push whose decode produced err; saturates at 16'hFFFF; cleared only by reset.
//   - In data mode it counts pushes attempted while full (s_valid && !s_ready), also saturating.
// - Macro AXI_RX_ERR_CNT_EN undefined: err_cnt tied to 16'h0; no counter logic synthesised.
// TESTING (DEPTH=4, IS_ADDR=1, ADDR_BASE=32'h9000_0000, ID_NUM=64 unless noted)
// - Reset release, then s_data=32'h9000_0010 with dev_rdy=1 -> valid_data next cycle, data=4, decode_err=0, count returns to 0.
// - Addresses 32'h9000_00FC, 32'h9000_0100, 32'h8FFF_FFFC, 32'h9000_0002 in turn:
//   - 32'h9000_00FC -> ID 63, no err
//   - the other three -> data=64 with decode_err=1
//   - err_cnt=3 with AXI_RX_ERR_CNT_EN, 0 without
// - dev_rdy=0, push 5 beats back-to-back -> s_ready drops after 4th accept, count=4; raise dev_rdy -> IDs pop in order, 5th accepted the cycle after first pop.
// - Continuous push+pop over 20 beats (forces pointer wrap) -> count stays 1, output order matches input, no loss/duplication.
// - rst_n low for 1 cycle with count=3 -> s_ready=0, valid_data=0, count=0 immediately; s_ready=1 the cycle after release, old entries never emitted.
// - IS_ADDR=0, BUS_WIDTH=32, DATA_WIDTH=16, s_data=32'hDEAD_BEEF -> data=16'hBEEF, decode_err=0.

Source files
------------

// File: rtl/axi_receive_fifo.sv
// axi_receive_fifo
//   Valid/ready slave receiver with a DEPTH-entry FIFO between the PS AXI
//   address/data channels and the register-map logic.
//   IS_ADDR=1 : byte address decoded to a word ID (range and alignment checked),
//               failing beats are stored as ID_NUM with decode_err set.
//   IS_ADDR=0 : beat passed through, resized to DATA_WIDTH.
//   Optional feature macro: AXI_RX_ERR_CNT_EN (enables the err_cnt counter;
//   when undefined err_cnt is tied to zero).
module axi_receive_fifo #(
   parameter int          BUS_WIDTH  = 32,
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 4,
   parameter int          IS_ADDR    = 0,
   parameter logic [31:0] ADDR_BASE  = 32'h9000_0000,
   parameter int          ID_NUM     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   input  logic [BUS_WIDTH-1:0]     s_data,
   output logic                     s_ready,
   output logic                     valid_data,
   output logic [DATA_WIDTH-1:0]    data,
   input  logic                     dev_rdy,
   output logic                     decode_err,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              err_cnt
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int MAX_W = (BUS_WIDTH > DATA_WIDTH) ? BUS_WIDTH : DATA_WIDTH;

   // Zero-extend or truncate a bus-width value to the stored data width.
   function automatic logic [DATA_WIDTH-1:0] fit_width(input logic [BUS_WIDTH-1:0] v);
      logic [MAX_W-1:0] wide;
      wide = MAX_W'(v);
      return wide[DATA_WIDTH-1:0];
   endfunction

   // Byte address -> word ID; out-of-window or misaligned addresses map to
   // the ID_NUM sentinel so the consumer never sees a plausible bogus ID.
   function automatic void decode_addr(input  logic [BUS_WIDTH-1:0]  addr,
                                       output logic [DATA_WIDTH-1:0] id,
                                       output logic                  err);
      logic [BUS_WIDTH-1:0] base;
      logic [BUS_WIDTH-1:0] offs;
      logic [BUS_WIDTH-1:0] word;
      base = BUS_WIDTH'(ADDR_BASE);
      offs = addr - base;
      word = offs >> 2;
      err  = (addr < base) || (addr[1:0] != 2'b00) || (word >= BUS_WIDTH'(ID_NUM));
      id   = err ? fit_width(BUS_WIDTH'(ID_NUM)) : fit_width(word);
   endfunction

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_nxt;
   logic [PTR_W-1:0]      rd_nxt;
   logic                  ready_r;
   logic                  empty;
   logic                  full_nxt;
   logic                  push;
   logic                  pop;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] dec_val;
   logic                  dec_err;
   logic [DATA_WIDTH-1:0] push_val;
   logic                  push_err;
   logic [DATA_WIDTH-1:0] mem_val [DEPTH];
   logic                  mem_err [DEPTH];

   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign rd_idx = rd_ptr[IDX_W-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign push   = s_valid && ready_r;
   assign pop    = !empty && dev_rdy;
   assign wr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
   assign rd_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;

   // Full when indices match but the wrap bits differ.
   assign full_nxt = (wr_nxt[IDX_W-1:0] == rd_nxt[IDX_W-1:0]) &&
                     (wr_nxt[IDX_W] != rd_nxt[IDX_W]);

   // Select the value/flag to store for the incoming beat.
   always_comb begin
      dec_val  = '0;
      dec_err  = 1'b0;
      push_val = '0;
      push_err = 1'b0;
      decode_addr(s_data, dec_val, dec_err);
      if (IS_ADDR != 0) begin
         push_val = dec_val;
         push_err = dec_err;
      end else begin
         push_val = fit_width(s_data);
         push_err = 1'b0;
      end
   end

   // Pointers and registered ready; ready comes only from next occupancy so
   // dev_rdy never reaches s_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ready_r <= 1'b0;
      end else begin
         wr_ptr  <= wr_nxt;
         rd_ptr  <= rd_nxt;
         ready_r <= !full_nxt;
      end
   end

   // Entry storage; contents are not reset, pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_val[wr_idx] <= push_val;
         mem_err[wr_idx] <= push_err;
      end
   end

   assign s_ready    = ready_r;
   assign valid_data = !empty;
   assign data       = empty ? '0 : mem_val[rd_idx];
   assign decode_err = !empty && mem_err[rd_idx];
   assign count      = wr_ptr - rd_ptr;

`ifdef AXI_RX_ERR_CNT_EN
   logic [15:0] err_cnt_r;
   logic        err_evt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Address mode counts bad decodes; data mode counts beats offered while full.
   assign err_evt = (IS_ADDR != 0) ? (push && push_err) : (s_valid && !ready_r);

   // Saturating error counter, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= 16'h0;
      end else if (err_evt) begin
         err_cnt_r <= sat_inc(err_cnt_r);
      end
   end

   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_axi_receive_fifo.sv
// Bench for axi_receive_fifo: address-mode instance checked cycle by cycle
// against a queue-based reference FIFO, plus a data-mode instance.
module tb_axi_receive_fifo;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        s_valid, s_ready, valid_data, dev_rdy, decode_err;
   logic [31:0] s_data, data;
   logic [2:0]  count;
   logic [15:0] err_cnt;

   logic        s_valid2, s_ready2, valid_data2, dev_rdy2, decode_err2;
   logic [31:0] s_data2;
   logic [15:0] data2;
   logic [2:0]  count2;
   logic [15:0] err_cnt2;

`ifdef AXI_RX_ERR_CNT_EN
   localparam bit ERRC = 1'b1;
`else
   localparam bit ERRC = 1'b0;
`endif

   localparam logic [31:0] BASE = 32'h9000_0000;

   always #5 clk = ~clk;

   axi_receive_fifo #(.BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .IS_ADDR(1),
                      .ADDR_BASE(BASE), .ID_NUM(64)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .valid_data(valid_data), .data(data),
      .dev_rdy(dev_rdy), .decode_err(decode_err), .count(count),
      .err_cnt(err_cnt));

   axi_receive_fifo #(.BUS_WIDTH(32), .DATA_WIDTH(16), .DEPTH(4), .IS_ADDR(0),
                      .ADDR_BASE(BASE), .ID_NUM(64)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_data(s_data2),
      .s_ready(s_ready2), .valid_data(valid_data2), .data(data2),
      .dev_rdy(dev_rdy2), .decode_err(decode_err2), .count(count2),
      .err_cnt(err_cnt2));

   typedef struct {
      logic [31:0] val;
      logic        err;
   } ent_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t q[$];
   int   exp_err  = 0;
   bit   chk_en   = 1'b0;
   ent_t mon_e;
   bit   mon_push, mon_pop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the address rules, plain integer arithmetic.
   function automatic ent_t ref_decode(input logic [31:0] a);
      longint unsigned ad;
      longint unsigned base;
      ent_t e;
      ad   = a;
      base = BASE;
      if (ad < base || (ad % 4) != 0 || (ad - base) / 4 >= 64) begin
         e.val = 32'd64;
         e.err = 1'b1;
      end else begin
         e.val = 32'((ad - base) / 4);
         e.err = 1'b0;
      end
      return e;
   endfunction

   // Monitor / scoreboard: compare DUT with the reference queue each cycle,
   // then apply this cycle's push/pop to the reference.
   always @(negedge clk) begin
      if (chk_en) begin
         check("count", 32'(count), 32'(q.size()));
         check("s_ready", 32'(s_ready), 32'(q.size() < 4));
         check("valid_data", 32'(valid_data), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check("data", data, q[0].val);
            check("decode_err", 32'(decode_err), 32'(q[0].err));
         end else begin
            check("data_empty", data, 32'd0);
            check("decode_err_empty", 32'(decode_err), 32'd0);
         end
         check("err_cnt", 32'(err_cnt), 32'(exp_err));
         mon_pop  = (q.size() != 0) && dev_rdy;
         mon_push = s_valid && (q.size() < 4);
         if (mon_pop) void'(q.pop_front());
         if (mon_push) begin
            mon_e = ref_decode(s_data);
            q.push_back(mon_e);
            if (ERRC && mon_e.err && exp_err < 65535) exp_err++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one beat (called at posedge+1), hold until accepted; leaves s_valid high.
   task automatic send(input logic [31:0] a);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data  = a;
      @(negedge clk);
      while (!s_ready && t < 100) begin
         t++;
         @(negedge clk);
      end
      if (!s_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got s_ready=0 required 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; dev_rdy = 1'b0;
      s_valid2 = 1'b0; s_data2 = '0; dev_rdy2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_valid_data", 32'(valid_data), 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_decode_err", 32'(decode_err), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      cyc(1);
      check("s_ready_after_rst", 32'(s_ready), 32'd1);
      chk_en = 1'b1;

      // Data-mode instance: truncation, stall while full, overflow attempts.
      s_valid2 = 1'b1; s_data2 = 32'hDEAD_BEEF;
      cyc(1);
      check("dm_valid", 32'(valid_data2), 32'd1);
      check("dm_data", 32'(data2), 32'h0000_BEEF);
      check("dm_decode_err", 32'(decode_err2), 32'd0);
      s_data2 = 32'h1234_5678; cyc(1);
      s_data2 = 32'hCAFE_0001; cyc(1);
      s_data2 = 32'h0000_FFFF; cyc(1);
      check("dm_count_full", 32'(count2), 32'd4);
      check("dm_s_ready_full", 32'(s_ready2), 32'd0);
      cyc(3);
      s_valid2 = 1'b0;
      check("dm_err_cnt", 32'(err_cnt2), ERRC ? 32'd3 : 32'd0);
      check("dm_head_stable", 32'(data2), 32'h0000_BEEF);
      dev_rdy2 = 1'b1;
      cyc(1);
      check("dm_second", 32'(data2), 32'h0000_5678);
      cyc(4);
      check("dm_drained", 32'(count2), 32'd0);
      dev_rdy2 = 1'b0;

      // First in-range address with the consumer ready.
      dev_rdy = 1'b1;
      send(32'h9000_0010);
      s_valid = 1'b0;
      check("first_valid", 32'(valid_data), 32'd1);
      check("first_id", data, 32'd4);
      check("first_err", 32'(decode_err), 32'd0);
      cyc(1);
      check("first_count", 32'(count), 32'd0);

      // Boundary addresses: last ID, one past, below base, misaligned.
      send(32'h9000_00FC);
      send(32'h9000_0100);
      send(32'h8FFF_FFFC);
      send(32'h9000_0002);
      s_valid = 1'b0;
      cyc(2);
      check("err_cnt_three", 32'(err_cnt), ERRC ? 32'd3 : 32'd0);

      // Fill with consumer stalled, then release and accept the fifth beat.
      dev_rdy = 1'b0;
      for (int i = 0; i < 4; i++) send(BASE + 32'(4 * (10 + i)));
      check("fill_count", 32'(count), 32'd4);
      check("fill_s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b1; s_data = BASE + 32'(4 * 14);
      cyc(1);
      dev_rdy = 1'b1;
      cyc(1);
      check("ready_after_pop", 32'(s_ready), 32'd1);
      check("count_after_pop", 32'(count), 32'd3);
      cyc(1);
      s_valid = 1'b0;
      check("count_after_fifth", 32'(count), 32'd3);
      cyc(6);
      check("drain_count", 32'(count), 32'd0);

      // Continuous push+pop streaming across many pointer wraps.
      dev_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) check("stream_count", 32'(count), 32'd1);
         send(BASE + 32'(4 * $urandom_range(0, 63)));
      end
      s_valid = 1'b0;
      cyc(3);

      // Reset mid-operation with three entries held.
      dev_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(BASE + 32'(4 * (40 + i)));
      s_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd3);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("mid_rst_s_ready", 32'(s_ready), 32'd0);
      check("mid_rst_valid", 32'(valid_data), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rel_s_ready_low", 32'(s_ready), 32'd0);
      q.delete();
      exp_err = 0;
      cyc(1);
      check("rel_s_ready_high", 32'(s_ready), 32'd1);
      check("rel_valid", 32'(valid_data), 32'd0);
      chk_en  = 1'b1;
      dev_rdy = 1'b1;
      cyc(3);

      // Randomised traffic: mixed valid, misaligned and out-of-window addresses.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 3);
         s_valid = ($urandom_range(0, 2) != 0);
         if (r == 0)      s_data = $urandom;
         else if (r == 1) s_data = BASE + 32'($urandom_range(0, 300));
         else             s_data = BASE + 32'(4 * $urandom_range(0, 63));
         dev_rdy = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      s_valid = 1'b0;
      dev_rdy = 1'b1;
      cyc(10);
      check("final_count", 32'(count), 32'd0);
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
